// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with Gray-coded mirror, terminal count, wrap/overflow
// and out-of-range load reporting. Wrap or saturate at the limits by parameter.
module mod_n_updown_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_gray,
   output logic             tc,
   output logic             wrap,
   output logic             load_err,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             lerr_nxt;
   logic             ovf_nxt;
   logic             lv_ok;
   logic             limit;

   assign tc    = up ? (q == QMAX) : (q == '0);
   // One extra bit so MODULUS == 2**WIDTH still compares correctly.
   assign lv_ok = ({1'b0, load_val} < MODW);
   assign limit = en && tc;

   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      lerr_nxt = 1'b0;
      ovf_nxt  = ovf;
      if (clr) begin
         q_nxt   = '0;
         ovf_nxt = 1'b0;
      end else if (load) begin
         if (lv_ok) begin
            q_nxt = load_val;
         end else begin
            q_nxt    = QMAX;
            lerr_nxt = 1'b1;
         end
      end else if (limit) begin
         wrap_nxt = 1'b1;
         ovf_nxt  = 1'b1;
         if (SATURATE == 0) q_nxt = up ? '0 : QMAX;
      end else if (en) begin
         q_nxt = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q        <= '0;
         q_gray   <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         q        <= q_nxt;
         q_gray   <= q_nxt ^ (q_nxt >> 1);
         wrap     <= wrap_nxt;
         load_err <= lerr_nxt;
         ovf      <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Random + directed bench: four counter configurations share one stimulus stream
// and are each compared against an arithmetic reference model.
module tb_mod_n_updown_counter;
   localparam int NI = 4;
   localparam int PW [NI] = '{4, 4, 2, 4};
   localparam int PM [NI] = '{10, 10, 4, 16};
   localparam int PS [NI] = '{0, 1, 0, 0};
   localparam int E35 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
   localparam int E40 [5]  = '{1, 2, 3, 0, 1};
   localparam int G40 [5]  = '{1, 3, 2, 0, 1};

   logic clk = 1'b0, rst, clr, load, en, up;
   logic [3:0] load_val;

   logic [3:0] q0, g0, q1, g1, q3, g3;
   logic [1:0] q2, g2;
   logic [NI-1:0] ot, ow, ol, oo;
   logic [3:0] oq [NI];
   logic [3:0] og [NI];

   int mq [NI], mw [NI], ml [NI], mo [NI];
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u0 (.clk(clk), .rst(rst), .clr(clr),
      .load(load), .load_val(load_val), .en(en), .up(up), .q(q0), .q_gray(g0), .tc(ot[0]),
      .wrap(ow[0]), .load_err(ol[0]), .ovf(oo[0]));
   mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .clr(clr),
      .load(load), .load_val(load_val), .en(en), .up(up), .q(q1), .q_gray(g1), .tc(ot[1]),
      .wrap(ow[1]), .load_err(ol[1]), .ovf(oo[1]));
   mod_n_updown_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(0)) u2 (.clk(clk), .rst(rst), .clr(clr),
      .load(load), .load_val(load_val[1:0]), .en(en), .up(up), .q(q2), .q_gray(g2), .tc(ot[2]),
      .wrap(ow[2]), .load_err(ol[2]), .ovf(oo[2]));
   mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u3 (.clk(clk), .rst(rst), .clr(clr),
      .load(load), .load_val(load_val), .en(en), .up(up), .q(q3), .q_gray(g3), .tc(ot[3]),
      .wrap(ow[3]), .load_err(ol[3]), .ovf(oo[3]));

   assign oq[0] = q0; assign og[0] = g0;
   assign oq[1] = q1; assign og[1] = g1;
   assign oq[2] = {2'b00, q2}; assign og[2] = {2'b00, g2};
   assign oq[3] = q3; assign og[3] = g3;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         mq[i] = 0; mw[i] = 0; ml[i] = 0; mo[i] = 0;
      end
   endtask

   // Reference: the rule set written directly as integer arithmetic.
   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         int m, lv;
         m  = PM[i];
         lv = int'(load_val) % (1 << PW[i]);
         mw[i] = 0; ml[i] = 0;
         if (clr) begin
            mq[i] = 0; mo[i] = 0;
         end else if (load) begin
            if (lv < m) mq[i] = lv;
            else begin mq[i] = m - 1; ml[i] = 1; end
         end else if (en) begin
            if ((up && mq[i] == m - 1) || (!up && mq[i] == 0)) begin
               mw[i] = 1; mo[i] = 1;
               if (PS[i] == 0) mq[i] = up ? 0 : m - 1;
            end else begin
               mq[i] = up ? mq[i] + 1 : mq[i] - 1;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NI; i++) begin
         int etc;
         etc = up ? int'(mq[i] == PM[i] - 1) : int'(mq[i] == 0);
         chk($sformatf("%s.u%0d.q", tag, i), int'(oq[i]), mq[i]);
         chk($sformatf("%s.u%0d.gray", tag, i), int'(og[i]), mq[i] ^ (mq[i] >> 1));
         chk($sformatf("%s.u%0d.wrap", tag, i), int'(ow[i]), mw[i]);
         chk($sformatf("%s.u%0d.lerr", tag, i), int'(ol[i]), ml[i]);
         chk($sformatf("%s.u%0d.ovf", tag, i), int'(oo[i]), mo[i]);
         chk($sformatf("%s.u%0d.tc", tag, i), int'(ot[i]), etc);
      end
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   // Asserts rst between edges, checks the immediate clear, holds it across an
   // edge with random controls, and releases at a negedge.
   task automatic do_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all({tag, ".async"});
      clr = 1'($urandom); load = 1'($urandom); en = 1'($urandom);
      load_val = 4'($urandom);
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = '0;
      @(negedge clk);
      do_reset("init");
      clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;

      en = 1'b1; up = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step("r35");
         chk("r35.q", int'(q0), E35[k]);
         chk("r35.wrap", int'(ow[0]), int'(k == 9));
         chk("r35.ovf", int'(oo[0]), int'(k >= 9));
         if (k == 8) chk("r35.gray9", int'(g0), 13);
         if (k < 5) begin
            chk("r40.q", int'(q2), E40[k]);
            chk("r40.gray", int'(g2), G40[k]);
            chk("r40.wrap", int'(ow[2]), int'(k == 3));
         end
      end

      load = 1'b1; load_val = 4'd2; en = 1'b0;
      step("r36.ld");
      chk("r36.q0", int'(q1), 2);
      load = 1'b0; en = 1'b1; up = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step("r36");
         chk("r36.q", int'(q1), (k < 2) ? 1 - k : 0);
         chk("r36.wrap", int'(ow[1]), int'(k >= 2));
      end

      load = 1'b1; load_val = 4'd13; en = 1'b0;
      step("r37.ld");
      chk("r37.q", int'(q0), 9);
      chk("r37.lerr", int'(ol[0]), 1);
      load = 1'b0;
      step("r37.hold");
      chk("r37.q2", int'(q0), 9);
      chk("r37.lerr2", int'(ol[0]), 0);

      load = 1'b1; load_val = 4'd5;
      step("r38.ld5");
      clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd3;
      step("r38.clr");
      chk("r38.q", int'(q0), 0);
      chk("r38.ovf", int'(oo[0]), 0);
      clr = 1'b0;
      step("r38.ld3");
      chk("r38.q3", int'(q0), 3);

      load_val = 4'd6; load = 1'b1; en = 1'b0;
      step("r39.ld");
      load = 1'b0; en = 1'b1; up = 1'b1;
      step("r39.up");
      chk("r39.q7", int'(q0), 7);
      do_reset("r39");
      chk("r39.tc", int'(ot[0]), int'(!up));
      clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
      step("r39.rel");
      chk("r39.q1", int'(q0), 1);

      for (int n = 0; n < 400; n++) begin
         clr      = ($urandom_range(0, 19) == 0);
         load     = ($urandom_range(0, 7) == 0);
         en       = ($urandom_range(0, 3) != 0);
         up       = ($urandom_range(0, 2) != 0) ? up : ~up;
         load_val = 4'($urandom);
         if ($urandom_range(0, 39) == 0) do_reset("rnd");
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; SHALL be >= 1.
REQ-002 Parameter MODULUS, default 10, count range 0..MODULUS-1; SHALL satisfy 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter SATURATE, default 0, 0 = wrap at limits, 1 = hold at limits.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clr  input  1  synchronous clear to 0.
REQ-007 load  input  1  synchronous parallel load of load_val.
REQ-008 load_val  input  WIDTH  value for load.
REQ-009 en  input  1  count enable.
REQ-010 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-011 q  output  WIDTH  registered binary count.
REQ-012 q_gray  output  WIDTH  registered Gray code of q, q_gray = q ^ (q >> 1), same cycle as q.
REQ-013 tc  output  1  combinational terminal count: (up && q==MODULUS-1) || (!up && q==0).
REQ-014 wrap  output  1  registered one-cycle pulse, set on the edge where a limit event occurs.
REQ-015 load_err  output  1  registered one-cycle pulse, set on the edge where an out-of-range load is applied.
REQ-016 ovf  output  1  sticky flag; set with any wrap pulse; cleared only by rst or clr.

Function
REQ-017 Per-edge priority SHALL be clr > load > en; no active control holds q.
REQ-018 clr: q<=0, q_gray<=0, ovf<=0, wrap<=0, load_err<=0.
REQ-019 load, load_val < MODULUS: q<=load_val; load_err<=0; wrap<=0.
REQ-020 load, load_val >= MODULUS: q<=MODULUS-1; load_err<=1 for one cycle.
REQ-021 en && up && q<MODULUS-1: q<=q+1.
REQ-022 en && !up && q>0: q<=q-1.
REQ-023 Limit event = en && tc at the edge (up at MODULUS-1, or down at 0).
REQ-024 Limit event, SATURATE=0: up -> q<=0, down -> q<=MODULUS-1; wrap<=1; ovf<=1.
REQ-025 Limit event, SATURATE=1: q holds; wrap<=1; ovf<=1.
REQ-026 wrap and load_err SHALL be 0 on every edge without their triggering event; no back-to-back merging.
REQ-027 Changing up while en=1 SHALL take effect on the next edge with no lost or extra count.
REQ-028 q SHALL never hold a value >= MODULUS after reset.
REQ-029 Arithmetic SHALL be computed WIDTH bits wide; with MODULUS = 2**WIDTH, wrap SHALL still assert on the 2**WIDTH-1 -> 0 transition.
REQ-030 Latency: q, q_gray, wrap, load_err, ovf update one edge after the sampled controls; tc follows q and up combinationally.

Reset
REQ-031 rst=1 SHALL force q=0, q_gray=0, wrap=0, load_err=0, ovf=0 immediately, without a clock edge.
REQ-032 While rst=1, all other inputs SHALL be ignored.
REQ-033 Assertion mid-count or mid-load SHALL discard the operation; the first edge after deassertion SHALL act normally on the sampled inputs.
REQ-034 After rst, tc SHALL equal !up, since q=0.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-035 rst pulse, then en=1 up=1 for 12 edges -> q: 1..9,0,1,2; wrap=1 only on the 9->0 edge; ovf=1 from that edge; q_gray at q=9 is 4'b1101.
REQ-036 SATURATE=1, load_val=2 load, then en=1 up=0 for 4 edges -> q: 2,1,0,0,0; wrap=1 on each edge taken at q=0; q stays 0.
REQ-037 load=1 load_val=4'd13 -> q=9, load_err=1 for one cycle; next edge load=0 en=0 -> q=9, load_err=0.
REQ-038 q=5, clr=load=en=1 together with load_val=3 -> q=0 and ovf=0; then load=en=1 with load_val=3 -> q=3, not 4.
REQ-039 q=7 counting up, rst asserted between edges -> q=0 immediately; after release with en=1 up=1 -> q=1 on the first edge.
REQ-040 WIDTH=2, MODULUS=4, SATURATE=0, en=1 up=1 for 5 edges -> q: 1,2,3,0,1; q_gray: 01,11,10,00,01; wrap=1 on the 3->0 edge only.
